alu_multicycle: RTL and testbench

//  Parametrised ALU for the processor datapath. Adds SUB, shift and multiply to FWD/ADD/AND/OR.

---
 rtl/alu_multicycle.sv | 190 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Brief    : Handshaked ALU; single-cycle logic/arith ops, iterative
//             shift/rotate and shift-add multiply.
//  Revision : 1.0  initial release
// ============================================================================

module alu_multicycle #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam logic [2:0] OP_FWD   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_SHIFT = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]       op;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] mcand;
    logic             shift_right;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;

    logic             accept;
    logic             last_step;
    logic             iterative;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] simple_result;
    logic             simple_carry;
    logic [WIDTH-1:0] step_work;
    logic [WIDTH-1:0] step_hi;

    assign accept    = IN_VALID && (state == IDLE);
    assign last_step = (state == BUSY) && (cnt == CNT_ONE);
    assign shamt     = DATA2[SHW-1:0];
    // A zero-distance shift/rotate has nothing to iterate and completes like a simple op.
    assign iterative = (SELECT == OP_MUL) ||
                       (((SELECT == OP_SHIFT) || (SELECT == OP_ROR)) && (shamt != '0));

    assign add_sum  = {1'b0, DATA1} + {1'b0, DATA2};
    assign sub_diff = {1'b0, DATA1} - {1'b0, DATA2};

    always_comb begin
        simple_result = DATA1;
        simple_carry  = 1'b0;
        case (SELECT)
            OP_FWD: simple_result = DATA2;
            OP_ADD: begin
                simple_result = add_sum[WIDTH-1:0];
                simple_carry  = add_sum[WIDTH];
            end
            OP_AND: simple_result = DATA1 & DATA2;
            OP_OR:  simple_result = DATA1 | DATA2;
            OP_SUB: begin
                simple_result = sub_diff[WIDTH-1:0];
                simple_carry  = ~sub_diff[WIDTH];
            end
            default: simple_result = DATA1;
        endcase
    end

    // One iteration: multiplier bits leave work[0] as product bits enter work[MSB].
    always_comb begin
        step_work = work;
        step_hi   = hi;
        mul_sum   = '0;
        case (op)
            OP_MUL: begin
                mul_sum   = {1'b0, hi} + (work[0] ? {1'b0, mcand} : '0);
                step_hi   = mul_sum[WIDTH:1];
                step_work = {mul_sum[0], work[WIDTH-1:1]};
            end
            OP_SHIFT: step_work = shift_right ? {1'b0, work[WIDTH-1:1]}
                                              : {work[WIDTH-2:0], 1'b0};
            OP_ROR:   step_work = {work[0], work[WIDTH-1:1]};
            default:  step_work = work;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = iterative ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op          <= OP_FWD;
            work        <= '0;
            hi          <= '0;
            mcand       <= '0;
            shift_right <= 1'b0;
            cnt         <= '0;
            result      <= '0;
            zero        <= 1'b1;
            carry       <= 1'b0;
        end else if (accept) begin
            op          <= SELECT;
            mcand       <= DATA1;
            hi          <= '0;
            shift_right <= DATA2[WIDTH-1];
            work        <= (SELECT == OP_MUL) ? DATA2 : DATA1;
            cnt         <= (SELECT == OP_MUL) ? CNT_FULL : {1'b0, shamt};
            if (!iterative) begin
                result <= simple_result;
                zero   <= (simple_result == '0);
                carry  <= simple_carry;
            end
        end else if (state == BUSY) begin
            work <= step_work;
            hi   <= step_hi;
            cnt  <= cnt - CNT_ONE;
            if (last_step) begin
                result <= step_work;
                zero   <= (step_work == '0);
                carry  <= (op == OP_MUL) && (step_hi != '0);
            end
        end
    end

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign RESULT    = result;
    assign ZERO      = zero;
    assign CARRY     = carry;

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle
//  Brief    : Self-checking bench for alu_multicycle against an arithmetic
//             reference model; directed corner cases then random traffic.
//  Revision : 1.0  initial release
// ============================================================================

module tb_alu_multicycle;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic [2:0]   sel = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .DATA1     (d1),
        .DATA2     (d2),
        .SELECT    (sel),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .RESULT    (result),
        .ZERO      (zero),
        .CARRY     (carry),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result, carry and cycles-to-done straight from the opcode definitions.
    function automatic void ref_model(input int op, input longint a, input longint b,
                                      output longint r, output longint c, output int lat);
        longint mask = (longint'(1) << W) - 1;
        longint p;
        int n;
        r = 0; c = 0; lat = 0;
        n = int'(b % W);
        case (op)
            0: r = b;
            1: begin p = a + b; r = p & mask; c = (p >> W) & 1; end
            2: r = a & b;
            3: r = a | b;
            4: begin r = (a - b) & mask; c = (a >= b) ? 1 : 0; end
            5: begin
                r = (((b >> (W-1)) & 1) == 1) ? (a >> n) : ((a << n) & mask);
                lat = n;
            end
            6: begin r = ((a >> n) | (a << (W - n))) & mask; lat = n; end
            default: begin p = a * b; r = p & mask; c = ((p >> W) != 0) ? 1 : 0; lat = W; end
        endcase
    endfunction

    task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        longint er, ec;
        int el;
        int cyc;
        ref_model(op, longint'(a), longint'(b), er, ec, el);
        @(negedge clk);
        d1 = a; d2 = b; sel = 3'(op);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check("idle_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        d1 = W'($urandom); d2 = W'($urandom); sel = 3'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("latency op%0d", op), cyc, el);
        check($sformatf("result op%0d %0h,%0h", op, a, b), result, er);
        check("zero", zero, (er == 0) ? 1 : 0);
        check($sformatf("carry op%0d", op), carry, ec);
        if (hold > 0) begin
            in_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
                check("hold_result", result, er);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("consume_in_ready", in_ready, 1);
        check("consume_out_valid", out_valid, 0);
        out_ready = 1'b0;
    endtask

    task automatic mul_reset();
        int seen;
        @(negedge clk);
        d1 = 8'hA7; d2 = 8'h5B; sel = 3'b111;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_carry", carry, 0);
        // Reset wins over a simultaneous accept.
        in_valid = 1'b1; sel = 3'b001; d1 = 8'h05; d2 = 8'h06;
        @(posedge clk); #1;
        check("rst_prio_in_ready", in_ready, 1);
        check("rst_prio_out_valid", out_valid, 0);
        check("rst_prio_result", result, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("no_stale_valid", seen, 0);
        out_ready = 1'b0;
    endtask

    typedef struct {
        int         op;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
    } vec_t;

    vec_t vecs[$] = '{
        '{1, 8'hF0, 8'h20, 0},
        '{4, 8'h05, 8'h05, 1},
        '{4, 8'h03, 8'h04, 0},
        '{5, 8'h81, 8'h03, 0},
        '{5, 8'h81, 8'h83, 2},
        '{6, 8'h81, 8'h01, 0},
        '{5, 8'h81, 8'h00, 0},
        '{6, 8'hA5, 8'h07, 0},
        '{0, 8'h11, 8'h3C, 0},
        '{2, 8'hF3, 8'h3C, 0},
        '{3, 8'h03, 8'h30, 0},
        '{7, 8'h10, 8'h11, 5},
        '{7, 8'h0F, 8'h0F, 0}
    };

    initial begin
        #500000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_zero", zero, 1);
        check("reset_carry", carry, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold);
        mul_reset();

        for (int i = 0; i < 60; i++) begin
            run_op(int'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
